// File: rtl/pipo_load_arbiter_pkg.sv
// Shared definitions for the PIPO load arbiter.
//   state_t  : FSM encoding (IDLE = 1'b0, HOLD = 1'b1)
//   calc_idw : owner/index width, max(1, clog2(n))
package pipo_arb_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } state_t;

  function automatic int calc_idw(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pipo_load_arbiter_rr_picker.sv
// Round-robin winner selection (purely combinational).
//   req     : per-requester request vector
//   ptr     : requester with highest priority this round
//   winner  : first set req bit scanning ptr, ptr+1, ... with wrap
//   any_req : at least one request present
module rr_picker
  import pipo_arb_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IDW  = calc_idw(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic [IDW-1:0]  winner,
  output logic            any_req
);

  logic [2*NREQ-1:0] w_dbl;
  logic [NREQ-1:0]   w_rot;
  logic [IDW-1:0]    w_off;
  logic [IDW:0]      w_sum;
  logic [IDW:0]      w_wrap;

  // Rotate so that bit 0 of w_rot corresponds to requester ptr.
  assign w_dbl = {req, req} >> ptr;
  assign w_rot = w_dbl[NREQ-1:0];

  // Lowest set bit wins; scanning downward lets the lowest index overwrite last.
  always_comb begin
    w_off = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (w_rot[i]) w_off = IDW'(i);
    end
  end

  // Un-rotate: (ptr + offset) mod NREQ, sum never exceeds 2*NREQ-2.
  assign w_sum   = {1'b0, ptr} + {1'b0, w_off};
  assign w_wrap  = w_sum - (IDW+1)'(NREQ);
  assign winner  = (w_sum >= (IDW+1)'(NREQ)) ? w_wrap[IDW-1:0] : w_sum[IDW-1:0];
  assign any_req = |req;

endmodule

// File: rtl/pipo_load_arbiter.sv
// Round-robin arbiter in front of a shared WIDTH-bit PIPO holding register.
// After each load the register is locked for HOLD_CYCLES cycles.
//   clk, rst    : clock, asynchronous active-high reset
//   clr         : synchronous clear of register contents (owner/ptr kept)
//   req         : level load requests, one per requester
//   req_data    : requester i data at [i*WIDTH +: WIDTH]
//   gnt         : registered one-hot grant pulse
//   pout        : register contents
//   pout_valid  : pout holds granted data
//   owner       : index of the last granted requester
//   busy        : hold window active, requests ignored
//
// state   | meaning
// IDLE    | waiting for requests, arbitrates every cycle
// HOLD    | register locked, counting down hold_cnt
module pipo_load_arbiter
  import pipo_arb_pkg::*;
#(
  parameter int NREQ        = 4,
  parameter int WIDTH       = 4,
  parameter int HOLD_CYCLES = 2,
  localparam int IDW        = calc_idw(NREQ)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] req_data,
  output logic [NREQ-1:0]       gnt,
  output logic [WIDTH-1:0]      pout,
  output logic                  pout_valid,
  output logic [IDW-1:0]        owner,
  output logic                  busy
);

  localparam int HCW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

  state_t           r_state,  w_state_nxt;
  logic [IDW-1:0]   r_ptr,    w_ptr_nxt;
  logic [HCW-1:0]   r_hold,   w_hold_nxt;
  logic [WIDTH-1:0] r_pout,   w_pout_nxt;
  logic             r_valid,  w_valid_nxt;
  logic [IDW-1:0]   r_owner,  w_owner_nxt;
  logic [NREQ-1:0]  r_gnt,    w_gnt_nxt;

  logic [IDW-1:0]   w_winner;
  logic             w_any_req;
  logic [WIDTH-1:0] w_sel_data;
  logic [IDW-1:0]   w_ptr_inc;

  rr_picker #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_picker (
    .req     (req),
    .ptr     (r_ptr),
    .winner  (w_winner),
    .any_req (w_any_req)
  );

  assign w_sel_data = req_data[w_winner*WIDTH +: WIDTH];
  assign w_ptr_inc  = (w_winner == IDW'(NREQ - 1)) ? '0 : w_winner + 1'b1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_ptr   <= '0;
      r_hold  <= '0;
      r_pout  <= '0;
      r_valid <= 1'b0;
      r_owner <= '0;
      r_gnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_ptr   <= w_ptr_nxt;
      r_hold  <= w_hold_nxt;
      r_pout  <= w_pout_nxt;
      r_valid <= w_valid_nxt;
      r_owner <= w_owner_nxt;
      r_gnt   <= w_gnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    w_hold_nxt  = r_hold;
    w_pout_nxt  = r_pout;
    w_valid_nxt = r_valid;
    w_owner_nxt = r_owner;
    w_gnt_nxt   = '0;

    if (clr) begin
      // Clear wins over any pending request; owner and ptr survive.
      w_state_nxt = ST_IDLE;
      w_hold_nxt  = '0;
      w_pout_nxt  = '0;
      w_valid_nxt = 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_any_req) begin
            w_pout_nxt  = w_sel_data;
            w_valid_nxt = 1'b1;
            w_owner_nxt = w_winner;
            w_gnt_nxt   = NREQ'(1) << w_winner;
            w_ptr_nxt   = w_ptr_inc;
            w_hold_nxt  = HCW'(HOLD_CYCLES - 1);
            w_state_nxt = ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (r_hold == '0) w_state_nxt = ST_IDLE;
          else              w_hold_nxt  = r_hold - 1'b1;
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  assign gnt        = r_gnt;
  assign pout       = r_pout;
  assign pout_valid = r_valid;
  assign owner      = r_owner;
  assign busy       = (r_state == ST_HOLD);

endmodule

// File: tb/tb_pipo_load_arbiter.sv
module tb_pipo_load_arbiter;

  localparam int NREQ = 4;
  localparam int WIDTH = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             clr;
  logic [3:0]       req;
  logic [15:0]      req_data;
  logic [3:0]       gnt;
  logic [3:0]       pout;
  logic             pout_valid;
  logic [1:0]       owner;
  logic             busy;

  typedef struct {
    logic [3:0] gnt;
    logic [3:0] pout;
    logic [1:0] owner;
  } exp_t;

  exp_t exp_q[$];
  int total = 0;
  int bad   = 0;

  pipo_load_arbiter #(.NREQ(4), .WIDTH(4), .HOLD_CYCLES(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .clr        (clr),
    .req        (req),
    .req_data   (req_data),
    .gnt        (gnt),
    .pout       (pout),
    .pout_valid (pout_valid),
    .owner      (owner),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive req for one edge; eg/eb are the hand-computed gnt and busy after it.
  // A grant pushes its expected data/owner for the monitor.
  task automatic cyc(input logic [3:0] r, input logic [3:0] eg, input logic eb,
                     input string nm, input bit push = 1'b1);
    exp_t e;
    req = r;
    if (eg != 4'b0 && push) begin
      e.gnt = eg;
      e.owner = 2'd0;
      for (int i = 0; i < 4; i++) if (eg[i]) e.owner = 2'(i);
      e.pout = req_data[e.owner*4 +: 4];
      exp_q.push_back(e);
    end
    tick();
    chk({nm, ".gnt"}, 32'(gnt), 32'(eg));
    chk({nm, ".busy"}, 32'(busy), 32'(eb));
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, ".pout"}, 32'(pout), 32'h0);
    chk({nm, ".valid"}, 32'(pout_valid), 32'h0);
    chk({nm, ".owner"}, 32'(owner), 32'h0);
    chk({nm, ".gnt"}, 32'(gnt), 32'h0);
    chk({nm, ".busy"}, 32'(busy), 32'h0);
  endtask

  // Monitor: every grant pulse must match the oldest expected grant.
  always @(negedge clk) begin
    if (gnt != 4'b0) begin
      if (exp_q.size() == 0) begin
        chk("sb.unexpected_gnt", 32'(gnt), 32'h0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("sb.gnt", 32'(gnt), 32'(e.gnt));
        chk("sb.pout", 32'(pout), 32'(e.pout));
        chk("sb.owner", 32'(owner), 32'(e.owner));
        chk("sb.valid", 32'(pout_valid), 32'h1);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, got running want finished");
    $fatal(1, "watchdog");
  end

  initial begin
    // 1: reset held with all requests up
    rst = 1'b1; clr = 1'b0; req = 4'b1111; req_data = 16'h4321;
    #1;
    chk_zero("rst_async");
    tick(); chk_zero("rst_c1");
    tick(); chk_zero("rst_c2");
    req = 4'b0000;
    rst = 1'b0;

    // 2: single requester, hold window of 2
    req_data = 16'h000A;
    cyc(4'b0001, 4'b0001, 1'b1, "t2_gnt");
    chk("t2.pout", 32'(pout), 32'hA);
    cyc(4'b0000, 4'b0000, 1'b1, "t2_hold1");
    cyc(4'b0000, 4'b0000, 1'b0, "t2_idle");
    chk("t2.pout_kept", 32'(pout), 32'hA);
    chk("t2.valid_kept", 32'(pout_valid), 32'h1);

    // 6: reset mid-HOLD (ptr=1 -> grant to 1), then ptr must restart at 0
    req_data = 16'h4321;
    cyc(4'b0010, 4'b0010, 1'b1, "t6_gnt", 1'b0);
    req = 4'b0000;
    #2 rst = 1'b1;
    #1 chk_zero("t6_async");
    tick(); chk_zero("t6_held");
    rst = 1'b0;

    // 3: all requesting, rotate 0,1,2,3,0, three cycles apart
    for (int g = 0; g < 5; g++) begin
      cyc(4'b1111, 4'(1 << (g % 4)), 1'b1, "t3_gnt");
      cyc(4'b1111, 4'b0000, 1'b1, "t3_h1");
      if (g < 4) cyc(4'b1111, 4'b0000, 1'b0, "t3_h2");
      else       cyc(4'b0000, 4'b0000, 1'b0, "t3_end");
    end

    // 4: ptr=1; grant 2 (ptr->3), then 0101 wraps to 0, then 2
    cyc(4'b0100, 4'b0100, 1'b1, "t4_g2");
    cyc(4'b0101, 4'b0000, 1'b1, "t4_h1");
    cyc(4'b0101, 4'b0000, 1'b0, "t4_h2");
    cyc(4'b0101, 4'b0001, 1'b1, "t4_wrap");
    cyc(4'b0101, 4'b0000, 1'b1, "t4_h3");
    cyc(4'b0101, 4'b0000, 1'b0, "t4_h4");
    cyc(4'b0101, 4'b0100, 1'b1, "t4_g2b");
    cyc(4'b0000, 4'b0000, 1'b1, "t4_h5");
    cyc(4'b0000, 4'b0000, 1'b0, "t4_h6");

    // 5: clr in IDLE blocks the grant; owner (2) and ptr (3) survive
    clr = 1'b1;
    cyc(4'b0010, 4'b0000, 1'b0, "t5_clr");
    clr = 1'b0;
    chk("t5.pout", 32'(pout), 32'h0);
    chk("t5.valid", 32'(pout_valid), 32'h0);
    chk("t5.owner", 32'(owner), 32'h2);
    cyc(4'b0010, 4'b0010, 1'b1, "t5_gnt1");

    // clr during HOLD aborts the window at once
    clr = 1'b1;
    cyc(4'b0000, 4'b0000, 1'b0, "t5_clr_hold");
    clr = 1'b0;
    chk("t5.valid_hold", 32'(pout_valid), 32'h0);
    chk("t5.owner_hold", 32'(owner), 32'h1);
    // ptr=2, request 3 and 0: 2 absent -> 3 wins
    cyc(4'b1001, 4'b1000, 1'b1, "t5_after");
    req = 4'b0000;

    @(negedge clk);
    #1;
    chk("sb.leftover", 32'(exp_q.size()), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
